// File: rtl/mux_arb_pkg.sv
// Shared sizes, select type and arbitration mode codes for the 4:1 mux scheduler.
package mux_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: round-robin starting after ptr, or lowest-index fixed priority.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    input  logic             mode,
    output logic             any,
    output sel_t             win,
    output logic [N_REQ-1:0] win_oh
);

    sel_t idx;

    // Candidates are scanned from lowest priority to highest so the last hit wins.
    always_comb begin
        any = |req;
        win = '0;
        idx = '0;
        if (mode) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win = sel_t'(i);
                end
            end
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                idx = ptr + sel_t'(k);
                if (req[idx]) begin
                    win = idx;
                end
            end
        end
        win_oh = any ? (4'b0001 << win) : 4'b0000;
    end

endmodule

// File: rtl/rr_mux4_scheduler.sv
// Arbitrates four requesters onto one 4:1 word mux and holds the chosen word
// in a one-entry output register with a valid/ready handshake.
module rr_mux4_scheduler
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    input  logic             out_ready
);

    localparam logic MODE = (PRIO_MODE == PRIO_FIXED);

    sel_t             ptr;
    logic             any;
    sel_t             win;
    logic [3:0]       win_oh;
    logic [WIDTH-1:0] word;
    logic             free;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .mode   (MODE),
        .any    (any),
        .win    (win),
        .win_oh (win_oh)
    );

    always_comb begin
        word = din0;
        case (win)
            2'd0:    word = din0;
            2'd1:    word = din1;
            2'd2:    word = din2;
            2'd3:    word = din3;
            default: word = din0;
        endcase
    end

    assign free = !out_valid || out_ready;

    // ptr resets to 3 so the first round-robin search starts at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            gnt       <= '0;
            sel       <= '0;
            ptr       <= 2'd3;
        end else if (free) begin
            if (any) begin
                dout      <= word;
                out_valid <= 1'b1;
                sel       <= win;
                gnt       <= win_oh;
                ptr       <= win;
            end else begin
                out_valid <= 1'b0;
                gnt       <= '0;
            end
        end else begin
            gnt <= '0;
        end
    end

endmodule

// File: tb/tb_rr_mux4_scheduler.sv
// Drives a round-robin and a fixed-priority scheduler with shared directed vectors
// and checks both against a behavioural model plus literal expectations.
module tb_rr_mux4_scheduler;

    typedef struct {
        int valid;
        int dout;
        int sel;
        int gnt;
        int ptr;
    } mstate_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [7:0] din [4];

    logic [3:0] gnt_rr, gnt_fx;
    logic [1:0] sel_rr, sel_fx;
    logic       valid_rr, valid_fx;
    logic [7:0] dout_rr, dout_fx;

    mstate_t model [2];
    bit      model_live;
    int      checks;
    int      failures;

    rr_mux4_scheduler #(.WIDTH(8), .PRIO_MODE(0)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din0      (din[0]),
        .din1      (din[1]),
        .din2      (din[2]),
        .din3      (din[3]),
        .gnt       (gnt_rr),
        .sel       (sel_rr),
        .out_valid (valid_rr),
        .dout      (dout_rr),
        .out_ready (out_ready)
    );

    rr_mux4_scheduler #(.WIDTH(8), .PRIO_MODE(1)) dut_fx (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din0      (din[0]),
        .din1      (din[1]),
        .din2      (din[2]),
        .din3      (din[3]),
        .gnt       (gnt_fx),
        .sel       (sel_fx),
        .out_valid (valid_fx),
        .dout      (dout_fx),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modelPick(logic [3:0] rq, int ptr, int mode);
        if (mode == 1) begin
            for (int i = 0; i < 4; i++)
                if (rq[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++)
                if (rq[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t modelStep(mstate_t s, logic r, logic [3:0] rq,
                                          logic rdy, int mode, int d0, int d1,
                                          int d2, int d3);
        mstate_t n;
        int      w;
        int      words [4];
        words = '{d0, d1, d2, d3};
        n = s;
        n.gnt = 0;
        if (r) begin
            n = '{valid: 0, dout: 0, sel: 0, gnt: 0, ptr: 3};
        end else if (s.valid == 0 || rdy) begin
            w = modelPick(rq, s.ptr, mode);
            if (w >= 0) begin
                n.valid = 1;
                n.dout  = words[w];
                n.sel   = w;
                n.gnt   = 1 << w;
                n.ptr   = w;
            end else begin
                n.valid = 0;
            end
        end
        return n;
    endfunction

    // The model advances on the same edge as the DUTs, from the inputs they sampled.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++)
            model[m] = modelStep(model[m], rst, req, out_ready, m,
                                 din[0], din[1], din[2], din[3]);
        model_live = 1'b1;
    end

    task automatic compareOne(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            compareOne("rr.gnt",   int'(gnt_rr),   model[0].gnt);
            compareOne("rr.sel",   int'(sel_rr),   model[0].sel);
            compareOne("rr.valid", int'(valid_rr), model[0].valid);
            compareOne("rr.dout",  int'(dout_rr),  model[0].dout);
            compareOne("fx.gnt",   int'(gnt_fx),   model[1].gnt);
            compareOne("fx.sel",   int'(sel_fx),   model[1].sel);
            compareOne("fx.valid", int'(valid_fx), model[1].valid);
            compareOne("fx.dout",  int'(dout_fx),  model[1].dout);
            compareOne("rr.onehot0", int'($onehot0(gnt_rr)), 1);
            compareOne("fx.onehot0", int'($onehot0(gnt_fx)), 1);
        end
    end

    // Called just after a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int which, input int eg,
                               input int ev, input int ed, input int es);
        if (which == 0) begin
            compareOne({name, ".gnt"},   int'(gnt_rr),   eg);
            compareOne({name, ".valid"}, int'(valid_rr), ev);
            compareOne({name, ".dout"},  int'(dout_rr),  ed);
            compareOne({name, ".sel"},   int'(sel_rr),   es);
        end else begin
            compareOne({name, ".gnt"},   int'(gnt_fx),   eg);
            compareOne({name, ".valid"}, int'(valid_fx), ev);
            compareOne({name, ".dout"},  int'(dout_fx),  ed);
            compareOne({name, ".sel"},   int'(sel_fx),   es);
        end
    endtask

    int rr_gnt  [5] = '{1, 2, 4, 8, 1};
    int rr_dout [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    int rr_sel  [5] = '{0, 1, 2, 3, 0};

    initial begin
        checks     = 0;
        failures   = 0;
        model_live = 1'b0;
        model[0]   = '{valid: 0, dout: 0, sel: 0, gnt: 0, ptr: 3};
        model[1]   = '{valid: 0, dout: 0, sel: 0, gnt: 0, ptr: 3};
        rst        = 1'b1;
        req        = 4'b0000;
        out_ready  = 1'b1;
        din        = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        @(negedge clk);

        $display("[TB] reset then idle");
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            checkOutput("idle", 0, 0, 0, 0, 0);
        end

        $display("[TB] round-robin fairness");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1);
            checkOutput("rr_fair", 0, rr_gnt[c], 1, rr_dout[c], rr_sel[c]);
            checkOutput("fx_all", 1, 1, 1, 8'hA0, 0);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("drain", 0, 0, 0, 8'hA0, 0);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 4'b0110, 1'b1);
        checkOutput("bp_cap", 0, 4'b0010, 1, 8'hA1, 1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b0110, 1'b0);
            checkOutput("bp_hold", 0, 0, 1, 8'hA1, 1);
        end
        applyStimulus(1'b0, 4'b0110, 1'b1);
        checkOutput("bp_resume", 0, 4'b0100, 1, 8'hA2, 2);

        $display("[TB] wrap and skip");
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("wrap0", 0, 4'b0001, 1, 8'hA0, 0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("wrap1", 0, 4'b0010, 1, 8'hA1, 1);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("wrap2", 0, 4'b0001, 1, 8'hA0, 0);

        $display("[TB] fixed priority");
        din = '{8'h10, 8'h21, 8'h32, 8'h43};
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1010, 1'b1);
            checkOutput("fx_hold1", 1, 4'b0010, 1, 8'h21, 1);
        end
        applyStimulus(1'b0, 4'b1000, 1'b1);
        checkOutput("fx_drop1", 1, 4'b1000, 1, 8'h43, 3);

        $display("[TB] single requester");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b0100, 1'b1);
            checkOutput("single", 0, 4'b0100, 1, 8'h32, 2);
        end

        $display("[TB] reset mid-operation");
        din = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("pre_rst_stall", 0, 0, 1, 8'h32, 2);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkOutput("mid_rst", 0, 0, 0, 0, 0);
        checkOutput("mid_rst_fx", 1, 0, 0, 0, 0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("post_rst", 0, 4'b0001, 1, 8'hA0, 0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("post_rst2", 0, 4'b0010, 1, 8'hA1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
